// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: PC, IR, MAR, MDR, Y, 64-bit Z and GPRs R3/R4/R7 around a shared bus and ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier/divider; otherwise mul/div yield Z = 0.
module cpu_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pc_out,
  input  logic             zlo_out,
  input  logic             zhi_out,
  input  logic             mdr_out,
  input  logic             r3_out,
  input  logic             r4_out,
  input  logic             r7_out,
  input  logic             pc_enable,
  input  logic             mar_enable,
  input  logic             mdr_enable,
  input  logic             ir_enable,
  input  logic             y_enable,
  input  logic             z_enable,
  input  logic             r3_enable,
  input  logic             r4_enable,
  input  logic             r7_enable,
  input  logic             pc_increment,
  input  logic             read,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] m_data_in,
  output logic [WIDTH-1:0] bus_q,
  output logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] ir_q,
  output logic [WIDTH-1:0] mar_q,
  output logic [WIDTH-1:0] r3_q,
  output logic [WIDTH-1:0] r4_q,
  output logic [WIDTH-1:0] r7_q,
  output logic [WIDTH-1:0] zhi_q,
  output logic [WIDTH-1:0] zlo_q
);

  localparam int unsigned ZW  = 2 * WIDTH;
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [WIDTH-1:0] mdr_r;
  logic [WIDTH-1:0] y_r;
  logic [ZW-1:0]    z_r;
  logic [WIDTH-1:0] alu_lo;
  logic [WIDTH-1:0] alu_hi;
  logic [SHW-1:0]   sh;
  logic [ZW-1:0]    rot_r;
  logic [ZW-1:0]    rot_l;

  assign zhi_q = z_r[ZW-1:WIDTH];
  assign zlo_q = z_r[WIDTH-1:0];

  // Fixed-priority bus driver mux
  always_comb begin
    bus_q = '0;
    if (mdr_out)      bus_q = mdr_r;
    else if (pc_out)  bus_q = pc_q;
    else if (zhi_out) bus_q = z_r[ZW-1:WIDTH];
    else if (zlo_out) bus_q = z_r[WIDTH-1:0];
    else if (r3_out)  bus_q = r3_q;
    else if (r4_out)  bus_q = r4_q;
    else if (r7_out)  bus_q = r7_q;
  end

  // Rotates taken from a doubled copy of Y so a zero amount passes Y straight through
  assign sh    = bus_q[SHW-1:0];
  assign rot_r = {y_r, y_r} >> sh;
  assign rot_l = {y_r, y_r} << sh;

`ifdef DATAPATH_MULDIV_EN
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] b_nz;
  logic signed [ZW-1:0]    prod;
  logic signed [WIDTH-1:0] quot;
  logic signed [WIDTH-1:0] rem;

  assign a_s  = $signed(y_r);
  assign b_s  = $signed(bus_q);
  // Keep the divider operand non-zero; the zero case is substituted below
  assign b_nz = (bus_q == '0) ? WIDTH'(1) : b_s;
  assign prod = ZW'(a_s) * ZW'(b_s);
  assign quot = a_s / b_nz;
  assign rem  = a_s % b_nz;
`endif

  // ALU: A = Y, B = bus
  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    case (op_code)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_lo = y_r + bus_q;
      OP_SUB:          alu_lo = y_r - bus_q;
      OP_AND, OP_ANDI: alu_lo = y_r & bus_q;
      OP_OR, OP_ORI:   alu_lo = y_r | bus_q;
      OP_ROR:          alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:          alu_lo = rot_l[ZW-1:WIDTH];
      OP_SHR:          alu_lo = y_r >> sh;
      OP_SHRA:         alu_lo = WIDTH'($signed(y_r) >>> sh);
      OP_SHL:          alu_lo = y_r << sh;
      OP_NEG:          alu_lo = '0 - bus_q;
      OP_NOT:          alu_lo = ~bus_q;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL: begin
        alu_lo = prod[WIDTH-1:0];
        alu_hi = prod[ZW-1:WIDTH];
      end
      OP_DIV: begin
        if (bus_q == '0) begin
          alu_hi = y_r;
        end else begin
          alu_lo = quot;
          alu_hi = rem;
        end
      end
`else
      OP_MUL, OP_DIV: begin
        alu_lo = '0;
        alu_hi = '0;
      end
`endif
      default: begin
        alu_lo = '0;
        alu_hi = '0;
      end
    endcase
  end

  // Register file; each register samples the bus on its load strobe
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_r <= '0;
      y_r   <= '0;
      z_r   <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      r7_q  <= '0;
    end else begin
      if (pc_enable)         pc_q <= bus_q;
      else if (pc_increment) pc_q <= pc_q + WIDTH'(1);
      if (ir_enable)  ir_q  <= bus_q;
      if (mar_enable) mar_q <= bus_q;
      if (mdr_enable) mdr_r <= read ? m_data_in : bus_q;
      if (y_enable)   y_r   <= bus_q;
      if (z_enable)   z_r   <= {alu_hi, alu_lo};
      if (r3_enable)  r3_q  <= bus_q;
      if (r4_enable)  r4_q  <= bus_q;
      if (r7_enable)  r7_q  <= bus_q;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed sequences, an ALU vector table and
// randomized ALU operations checked against a behavioural model.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic        pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out;
  logic        pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
  logic        r3_enable, r4_enable, r7_enable;
  logic        pc_increment, read;
  logic [4:0]  op_code;
  logic [31:0] m_data_in;
  logic [31:0] bus_q, pc_q, ir_q, mar_q, r3_q, r4_q, r7_q, zhi_q, zlo_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[$];

  cpu_datapath #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
    .r3_out(r3_out), .r4_out(r4_out), .r7_out(r7_out),
    .pc_enable(pc_enable), .mar_enable(mar_enable), .mdr_enable(mdr_enable),
    .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
    .r3_enable(r3_enable), .r4_enable(r4_enable), .r7_enable(r7_enable),
    .pc_increment(pc_increment), .read(read), .op_code(op_code), .m_data_in(m_data_in),
    .bus_q(bus_q), .pc_q(pc_q), .ir_q(ir_q), .mar_q(mar_q),
    .r3_q(r3_q), .r4_q(r4_q), .r7_q(r7_q), .zhi_q(zhi_q), .zlo_q(zlo_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    {pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out} = '0;
    {pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable} = '0;
    {r3_enable, r4_enable, r7_enable, pc_increment, read} = '0;
    op_code   = 5'd0;
    m_data_in = 32'd0;
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    m_data_in = v; read = 1'b1; mdr_enable = 1'b1;
    tick();
  endtask

  // Y <= a, then Z <= ALU(op, Y, b) with b driven from MDR
  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_mdr(a);
    mdr_out = 1'b1; y_enable = 1'b1;
    tick();
    load_mdr(b);
    mdr_out = 1'b1; op_code = op; z_enable = 1'b1;
    tick();
  endtask

  // Reference ALU: shifts and rotates done one bit at a time, mul/div via 64-bit integers
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n  = int'(b[4:0]);
    logic [31:0] r  = 32'd0;
    logic [31:0] hi = 32'd0;
    longint      la, lb;
    logic [63:0] t;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: r = a + b;
      5'd4:         r = a - b;
      5'd5, 5'd13:  r = a & b;
      5'd6, 5'd14:  r = a | b;
      5'd7:  begin r = a; repeat (n) r = {r[0], r[31:1]}; end
      5'd8:  begin r = a; repeat (n) r = {r[30:0], r[31]}; end
      5'd9:  begin r = a; repeat (n) r = {1'b0, r[31:1]}; end
      5'd10: begin r = a; repeat (n) r = {r[31], r[31:1]}; end
      5'd11: begin r = a; repeat (n) r = {r[30:0], 1'b0}; end
      5'd17: r = 32'd0 - b;
      5'd18: r = ~b;
`ifdef DATAPATH_MULDIV_EN
      5'd16: begin t = 64'(la * lb); r = t[31:0]; hi = t[63:32]; end
      5'd15: begin
        if (b == 32'd0) begin
          r = 32'd0; hi = a;
        end else begin
          t = 64'(la / lb); r = t[31:0];
          t = 64'(la % lb); hi = t[31:0];
        end
      end
`endif
      default: r = 32'd0;
    endcase
    return {hi, r};
  endfunction

  function automatic void add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] lo, input logic [31:0] hi);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0] m;
    logic [4:0]  op;
    logic [31:0] a, b;

    add_vec(5'b01010, 32'h8000_0000, 32'd1, 32'hC000_0000, 32'd0);
    add_vec(5'b01001, 32'h8000_0000, 32'd1, 32'h4000_0000, 32'd0);
    add_vec(5'b01000, 32'h8000_0000, 32'd1, 32'h0000_0001, 32'd0);
    add_vec(5'b01011, 32'h8000_0000, 32'd1, 32'h0000_0000, 32'd0);
    add_vec(5'b10001, 32'h1234_5678, 32'd1, 32'hFFFF_FFFF, 32'd0);
    add_vec(5'b00011, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'd0);
    add_vec(5'b01100, 32'h0000_0010, 32'h20, 32'h0000_0030, 32'd0);
    add_vec(5'b00100, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'd0);
    add_vec(5'b01101, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 32'd0);
    add_vec(5'b00110, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 32'd0);
    add_vec(5'b10010, 32'd0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'd0);
    add_vec(5'b00111, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0);
    add_vec(5'b00111, 32'h1234_5678, 32'd36, 32'h8123_4567, 32'd0);
    add_vec(5'b01011, 32'h0000_0003, 32'd33, 32'h0000_0006, 32'd0);
    add_vec(5'b01010, 32'h7000_0000, 32'd32, 32'h7000_0000, 32'd0);
    add_vec(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    add_vec(5'b11111, 32'h1234_5678, 32'd1, 32'd0, 32'd0);
`ifdef DATAPATH_MULDIV_EN
    add_vec(5'b01111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    add_vec(5'b10000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
    add_vec(5'b01111, 32'h0000_1234, 32'd0, 32'h0000_0000, 32'h0000_1234);
    add_vec(5'b10000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
`else
    add_vec(5'b01111, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    add_vec(5'b10000, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
`endif

    idle();
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc_q, 32'd0);
    check("rst_zlo", zlo_q, 32'd0);
    clr = 1'b1;
    tick();
    check("rst_bus", bus_q, 32'd0);
    check("rst_ir", ir_q, 32'd0);
    check("rst_mar", mar_q, 32'd0);
    check("rst_r3", r3_q, 32'd0);
    check("rst_r4", r4_q, 32'd0);
    check("rst_r7", r7_q, 32'd0);
    check("rst_zhi", zhi_q, 32'd0);

    // Instruction fetch
    pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1;
    tick();
    check("fetch_mar", mar_q, 32'd0);
    check("fetch_pc", pc_q, 32'd1);
    load_mdr(32'h3A1B_8000);
    mdr_out = 1'b1; ir_enable = 1'b1;
    tick();
    check("fetch_ir", ir_q, 32'h3A1B_8000);

    // Register load through MDR
    load_mdr(32'h22);
    mdr_out = 1'b1; r3_enable = 1'b1;
    tick();
    check("load_r3", r3_q, 32'h22);
    load_mdr(32'h4);
    mdr_out = 1'b1; r7_enable = 1'b1;
    tick();
    check("load_r7", r7_q, 32'h4);

    // ror R3 by R7 into R4
    r3_out = 1'b1; y_enable = 1'b1;
    tick();
    r7_out = 1'b1; op_code = 5'b00111; z_enable = 1'b1;
    tick();
    zlo_out = 1'b1; r4_enable = 1'b1;
    tick();
    check("ror_r4", r4_q, 32'h2000_0002);
    check("ror_zhi", zhi_q, 32'd0);

    // Bus priority: drivers added from lowest to highest priority
    r7_out = 1'b1; r4_out = 1'b1; #1;
    check("prio_r4", bus_q, 32'h2000_0002);
    r3_out = 1'b1; #1;
    check("prio_r3", bus_q, 32'h22);
    zlo_out = 1'b1; #1;
    check("prio_zlo", bus_q, 32'h2000_0002);
    zhi_out = 1'b1; #1;
    check("prio_zhi", bus_q, 32'd0);
    pc_out = 1'b1; #1;
    check("prio_pc", bus_q, 32'd1);
    mdr_out = 1'b1; #1;
    check("prio_mdr", bus_q, 32'h4);
    idle(); #1;
    check("bus_idle", bus_q, 32'd0);

    // Z driven and loaded in the same cycle: bus shows old ZLO, Z takes Y + old ZLO
    zlo_out = 1'b1; z_enable = 1'b1; op_code = 5'b00011; #1;
    check("same_bus", bus_q, 32'h2000_0002);
    tick();
    check("same_zlo", zlo_q, 32'h2000_0024);

    // PC load beats increment, then increment wraps
    load_mdr(32'hFFFF_FFFF);
    mdr_out = 1'b1; pc_enable = 1'b1; pc_increment = 1'b1;
    tick();
    check("pc_load", pc_q, 32'hFFFF_FFFF);
    pc_increment = 1'b1;
    tick();
    check("pc_wrap", pc_q, 32'd0);
    check("hold_r3", r3_q, 32'h22);
    check("hold_ir", ir_q, 32'h3A1B_8000);

    // MDR with read=0 samples the bus
    r3_out = 1'b1; mdr_enable = 1'b1;
    tick();
    mdr_out = 1'b1; #1;
    check("mdr_bus", bus_q, 32'h22);
    idle();

    foreach (vecs[i]) begin
      run_alu(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_lo op=%b", i, vecs[i].op), zlo_q, vecs[i].lo);
      check($sformatf("vec%0d_hi op=%b", i, vecs[i].op), zhi_q, vecs[i].hi);
    end

    for (int k = 0; k < 150; k++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      m = model(op, a, b);
      run_alu(op, a, b);
      check($sformatf("rnd%0d_lo op=%b a=%h b=%h", k, op, a, b), zlo_q, m[31:0]);
      check($sformatf("rnd%0d_hi op=%b a=%h b=%h", k, op, a, b), zhi_q, m[63:32]);
    end

    // Asynchronous reset away from a clock edge
    #2;
    clr = 1'b0;
    #1;
    check("arst_r3", r3_q, 32'd0);
    check("arst_ir", ir_q, 32'd0);
    clr = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
